// File: rtl/unsaved_cpu_cpu_ocimem_pkg.sv
// Shared types and JTAG data-word field positions for the debug-RAM monitor controller.
package unsaved_cpu_cpu_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RDATA = 2'd2
    } ocimem_state_e;

    localparam int JDO_W           = 38;
    localparam int JDO_ADDR_LSB    = 17;
    localparam int JDO_RD_BIT      = 34;
    localparam int JDO_WDATA_MSB   = 34;
    localparam int JDO_WDATA_LSB   = 3;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/unsaved_cpu_cpu_ocimem_timeout.sv
// Stall counter for an outstanding debug-RAM request; pulses expired on the
// stalled cycle that brings the count to TIMEOUT.
module unsaved_cpu_cpu_ocimem_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = count_en && !clear && (count_reg == CNT_LAST);

endmodule

// File: rtl/unsaved_cpu_cpu_ocimem_ctrl.sv
// Turns JTAG debug-slave commands into single-word accesses on the on-chip debug RAM
// and maintains the monitor address/data registers and ready/error status.
module unsaved_cpu_cpu_ocimem_ctrl
    import unsaved_cpu_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_waitreq,
    input  logic              mem_err,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    ocimem_state_e     state_reg, state_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [ADDR_W-1:0] mon_a_reg, mon_a_next;
    logic [31:0]       mon_d_reg, mon_d_next;
    logic              ready_reg, ready_next;
    logic              error_reg, error_next;
    logic              err_pend_reg, err_pend_next;

    logic              cnt_clear;
    logic              cnt_en;
    logic              expired;

    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_wdata;
    logic              any_cmd;
    logic              unused_jdo;

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    assign any_cmd    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    assign cnt_en = (state_reg == ST_REQ) && mem_waitreq;

    unsaved_cpu_cpu_ocimem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .count_en (cnt_en),
        .expired  (expired)
    );

    always_comb begin
        state_next    = state_reg;
        req_next      = req_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        mon_a_next    = mon_a_reg;
        mon_d_next    = mon_d_reg;
        ready_next    = ready_reg;
        error_next    = error_reg;
        err_pend_next = err_pend_reg;
        cnt_clear     = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // Priority ocimem_a > ocimem_b > no_action_a; losers are ignored.
                if (take_action_ocimem_a) begin
                    mon_a_next = jdo_addr;
                    error_next = 1'b0;
                    if (jdo[JDO_RD_BIT]) begin
                        state_next = ST_REQ;
                        req_next   = 1'b1;
                        we_next    = 1'b0;
                        addr_next  = jdo_addr;
                        ready_next = 1'b0;
                        cnt_clear  = 1'b1;
                    end else begin
                        ready_next = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    state_next = ST_REQ;
                    req_next   = 1'b1;
                    we_next    = 1'b1;
                    addr_next  = mon_a_reg;
                    wdata_next = jdo_wdata;
                    ready_next = 1'b0;
                    cnt_clear  = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    state_next = ST_REQ;
                    req_next   = 1'b1;
                    we_next    = 1'b0;
                    addr_next  = mon_a_reg;
                    ready_next = 1'b0;
                    cnt_clear  = 1'b1;
                end
            end
            ST_REQ: begin
                error_next = error_reg | any_cmd;
                if (!mem_waitreq) begin
                    req_next = 1'b0;
                    if (we_reg) begin
                        state_next = ST_IDLE;
                        mon_a_next = mon_a_reg + 1'b1;
                        mon_d_next = wdata_reg;
                        ready_next = 1'b1;
                        error_next = error_reg | any_cmd | mem_err;
                    end else begin
                        state_next    = ST_RDATA;
                        err_pend_next = mem_err;
                    end
                end else if (expired) begin
                    state_next = ST_IDLE;
                    req_next   = 1'b0;
                    ready_next = 1'b1;
                    error_next = 1'b1;
                end
            end
            ST_RDATA: begin
                state_next = ST_IDLE;
                mon_d_next = mem_rdata;
                mon_a_next = mon_a_reg + 1'b1;
                ready_next = 1'b1;
                error_next = error_reg | any_cmd | err_pend_reg;
            end
            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            mon_a_reg    <= '0;
            mon_d_reg    <= '0;
            ready_reg    <= 1'b0;
            error_reg    <= 1'b0;
            err_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            mon_a_reg    <= mon_a_next;
            mon_d_reg    <= mon_d_next;
            ready_reg    <= ready_next;
            error_reg    <= error_next;
            err_pend_reg <= err_pend_next;
        end
    end

    assign mem_req       = req_reg;
    assign mem_we        = we_reg;
    assign mem_addr      = addr_reg;
    assign mem_wdata     = wdata_reg;
    assign MonAReg       = mon_a_reg;
    assign MonDReg       = mon_d_reg;
    assign monitor_ready = ready_reg;
    assign monitor_error = error_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule
